vr_vc_converter: RTL and testbench

//   Valid/ready -> valid/credit converter; sender-side mate of the credit-based link.

---
 rtl/vr_vc_converter.sv | 57 +++++
 tb/tb_vr_vc_converter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/vr_vc_converter.sv
// Valid/ready to valid/credit converter: accepts flits from a valid/ready producer
// and forwards them over a credit-controlled link with a single output register.
module vr_vc_converter #(
    parameter int DATA_WIDTH = 8,
    parameter int CREDIT_NUM = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             s_data_i,
    input  logic                              s_valid_i,
    output logic                              s_ready_o,
    output logic [DATA_WIDTH-1:0]             m_data_o,
    output logic                              m_valid_o,
    input  logic                              m_credit_i,
    output logic [$clog2(CREDIT_NUM+1)-1:0]   credit_cnt_o,
    output logic                              credit_err_o
);

    localparam int CW = $clog2(CREDIT_NUM + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CREDIT_NUM);

    logic [CW-1:0] cnt;
    logic          xfer;
    logic          cnt_full;

    // Ready comes only from registered credit state, so a returned credit is
    // usable one cycle later and there is no comb path credit -> ready.
    assign s_ready_o    = (cnt != '0);
    assign xfer         = s_valid_i & s_ready_o;
    assign cnt_full     = (cnt == CNT_MAX);
    assign credit_cnt_o = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            m_valid_o    <= 1'b0;
            m_data_o     <= '0;
            credit_err_o <= 1'b0;
        end else begin
            m_valid_o <= xfer;
            if (xfer) begin
                m_data_o <= s_data_i;
            end

            if (xfer && !m_credit_i) begin
                cnt <= cnt - 1'b1;
            end else if (!xfer && m_credit_i) begin
                if (cnt_full) begin
                    credit_err_o <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vr_vc_converter.sv
// Self-checking bench for vr_vc_converter: directed vector table for the corner
// cases, then a randomized run against a credit-loop receiver model.
module tb_vr_vc_converter;

    localparam int DW = 8;
    localparam int CN = 2;
    localparam int CW = $clog2(CN + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_credit = 1'b0;
    logic [CW-1:0] credit_cnt;
    logic          credit_err;

    int n_cmp = 0;
    int n_err = 0;

    vr_vc_converter #(.DATA_WIDTH(DW), .CREDIT_NUM(CN)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data_i     (s_data),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_credit_i   (m_credit),
        .credit_cnt_o (credit_cnt),
        .credit_err_o (credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          valid;
        logic [DW-1:0] data;
        logic          credit;
        logic          e_mv;
        logic [DW-1:0] e_md;
        int            e_cnt;
        logic          e_err;
        logic          e_rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [DW-1:0] d, input logic c,
                       input logic mv, input logic [DW-1:0] md, input int cnt,
                       input logic err, input logic rdy);
        vec_t t;
        t.rst = r; t.valid = v; t.data = d; t.credit = c;
        t.e_mv = mv; t.e_md = md; t.e_cnt = cnt; t.e_err = err; t.e_rdy = rdy;
        vecs.push_back(t);
    endtask

    // Random phase state
    int          mcred;
    int          rx_occ;
    int          crq[$];
    logic [DW-1:0] expq[$];
    int          it;
    int          accepted;
    logic        hold;
    logic        xfer;

    initial begin
        //  rst v  data   cr | mv  md    cnt err rdy
        // reset then two initial credits
        add(1, 0, 8'h00, 0,   0, 8'h00, 0, 0, 0);
        add(0, 0, 8'h00, 1,   0, 8'h00, 1, 0, 1);
        add(0, 0, 8'h00, 1,   0, 8'h00, 2, 0, 1);
        // three flits with only two credits: third stalls
        add(0, 1, 8'hA1, 0,   1, 8'hA1, 1, 0, 1);
        add(0, 1, 8'hB2, 0,   1, 8'hB2, 0, 0, 0);
        add(0, 1, 8'hC3, 0,   0, 8'hB2, 0, 0, 0);
        add(0, 1, 8'hC3, 0,   0, 8'hB2, 0, 0, 0);
        // credit while stalled, then xfer and credit together at cnt==1
        add(0, 0, 8'hC3, 1,   0, 8'hB2, 1, 0, 1);
        add(0, 1, 8'hC3, 1,   1, 8'hC3, 1, 0, 1);
        // overflow makes error sticky
        add(0, 0, 8'h00, 1,   0, 8'hC3, 2, 0, 1);
        add(0, 0, 8'h00, 1,   0, 8'hC3, 2, 1, 1);
        add(0, 0, 8'h00, 0,   0, 8'hC3, 2, 1, 1);
        add(0, 1, 8'h5A, 0,   1, 8'h5A, 1, 1, 1);
        add(0, 0, 8'h00, 1,   0, 8'h5A, 2, 1, 1);
        // reset the cycle after an xfer
        add(0, 1, 8'h6B, 0,   1, 8'h6B, 1, 1, 1);
        add(1, 0, 8'h00, 0,   0, 8'h00, 0, 0, 0);
        add(0, 0, 8'h00, 0,   0, 8'h00, 0, 0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; s_valid = vecs[i].valid;
            s_data = vecs[i].data; m_credit = vecs[i].credit;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_m_valid", i), int'(m_valid), int'(vecs[i].e_mv));
            chk($sformatf("vec%0d_m_data", i), int'(m_data), int'(vecs[i].e_md));
            chk($sformatf("vec%0d_cnt", i), int'(credit_cnt), vecs[i].e_cnt);
            chk($sformatf("vec%0d_err", i), int'(credit_err), int'(vecs[i].e_err));
            chk($sformatf("vec%0d_ready", i), int'(s_ready), int'(vecs[i].e_rdy));
        end

        // Randomized loop with a receiver of depth CN returning credits 3 cycles after each flit
        rst = 1'b1; s_valid = 1'b0; m_credit = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mcred = 0; rx_occ = 0; it = 0; accepted = 0; hold = 1'b0;
        for (int k = 0; k < CN; k++) crq.push_back(k);

        while (accepted < 500 && it < 20000) begin
            if (!hold) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = DW'($urandom);
            end
            m_credit = (crq.size() > 0 && crq[0] == it);
            if (m_credit) void'(crq.pop_front());

            chk("rnd_ready", int'(s_ready), int'(mcred > 0));
            xfer = s_valid && (mcred > 0);
            if (xfer) begin
                expq.push_back(s_data);
                accepted++;
            end
            mcred = mcred - int'(xfer) + int'(m_credit);
            if (m_credit) rx_occ--;
            hold = s_valid && !xfer;

            @(posedge clk); #1;
            chk("rnd_m_valid", int'(m_valid), int'(xfer));
            if (m_valid) begin
                rx_occ++;
                chk("rnd_rx_overflow", int'(rx_occ <= CN), 1);
                crq.push_back(it + 3);
                if (expq.size() > 0)
                    chk("rnd_order", int'(m_data), int'(expq.pop_front()));
                else
                    chk("rnd_unexpected_flit", 1, 0);
            end
            chk("rnd_cnt", int'(credit_cnt), mcred);
            chk("rnd_err", int'(credit_err), 0);
            it++;
        end
        chk("rnd_flits_accepted", accepted, 500);
        chk("rnd_flits_pending", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
